// File: rtl/core_pkg.sv
// Shared RV32I core definitions.
// Opcodes, ALU operations and the D/E control bundle.
package core_pkg;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       src_a_pc;
    logic       src_b_imm;
    logic       reg_we;
    logic       mem_we;
    logic       mem_rd;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       illegal;
  } id_ex_ctrl_t;

  function automatic alu_op_t alu_dec(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_t op;
    unique case (f3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/latch.sv
// Pipeline register with sync reset, flush and enable.
// Priority: reset > clear > enable.
module latch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (clear) q <= '0;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/regfile.sv
// 32 x XLEN register file, 2R1W.
// x0 is hardwired to zero; reads see a same-cycle write.
module regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && rd != 5'd0) begin
      mem[rd] <= wd;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [4:0] a);
    logic [XLEN-1:0] v;
    if (a == 5'd0)              v = '0;
    else if (we && rd == a)     v = wd;
    else                        v = mem[a];
    return v;
  endfunction

  assign rs1_data = rd_port(rs1);
  assign rs2_data = rd_port(rs2);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: regfile read, immediate and control
// generation, registered into the D/E latch.
module decode_stage
  import core_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int XLEN    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               wb_we_i,
  input  logic [4:0]         wb_rd_i,
  input  logic [XLEN-1:0]    wb_data_i,
  input  logic               latch_en_i,
  input  logic               latch_clear_i,
  output logic [4:0]         rs1_o,
  output logic [4:0]         rs2_o,
  output logic [XLEN-1:0]    rs1_data_o,
  output logic [XLEN-1:0]    rs2_data_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [4:0]         rd_o,
  output logic [2:0]         funct3_o,
  output logic [3:0]         alu_op_o,
  output logic               alu_src_a_pc_o,
  output logic               alu_src_b_imm_o,
  output logic               reg_we_o,
  output logic               mem_we_o,
  output logic               mem_rd_o,
  output logic               branch_o,
  output logic               jump_o,
  output logic               jalr_o,
  output logic               illegal_o
);

  localparam int DW = 3 * XLEN + PC_W;

  logic [31:0]     ins;
  logic [6:0]      opc;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] r1, r2, imm;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            bad;
  id_ex_ctrl_t     c, cq;
  logic [DW-1:0]   dq;

  assign ins   = instr_i[31:0];
  assign opc   = ins[6:0];
  assign f3    = ins[14:12];
  assign f7    = ins[31:25];
  assign rs1_o = ins[19:15];
  assign rs2_o = ins[24:20];

  assign imm_i = {{(XLEN-11){ins[31]}}, ins[30:20]};
  assign imm_s = {{(XLEN-11){ins[31]}}, ins[30:25], ins[11:7]};
  assign imm_b = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25],
                  ins[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){ins[31]}}, ins[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20],
                  ins[30:21], 1'b0};

  regfile #(.XLEN(XLEN)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .rs1      (rs1_o),
    .rs2      (rs2_o),
    .rs1_data (r1),
    .rs2_data (r2),
    .we       (wb_we_i),
    .rd       (wb_rd_i),
    .wd       (wb_data_i)
  );

  always_comb begin
    c        = '0;
    c.funct3 = f3;
    c.rd     = ins[11:7];
    imm      = '0;
    bad      = 1'b0;
    unique case (1'b1)
      opc == OP_LUI: begin
        c.alu_op = ALU_PASS_B; c.src_b_imm = 1'b1;
        c.reg_we = 1'b1; imm = imm_u;
      end
      opc == OP_AUIPC: begin
        c.src_a_pc = 1'b1; c.src_b_imm = 1'b1;
        c.reg_we = 1'b1; imm = imm_u;
      end
      opc == OP_JAL: begin
        c.src_a_pc = 1'b1; c.src_b_imm = 1'b1;
        c.jump = 1'b1; c.reg_we = 1'b1; imm = imm_j;
      end
      opc == OP_JALR: begin
        bad = (f3 != 3'd0);
        c.src_b_imm = 1'b1; c.jalr = 1'b1;
        c.reg_we = 1'b1; imm = imm_i;
      end
      opc == OP_BRANCH: begin
        bad = (f3 == 3'd2) || (f3 == 3'd3);
        c.alu_op = ALU_SUB; c.branch = 1'b1; imm = imm_b;
      end
      opc == OP_LOAD: begin
        bad = (f3 == 3'd3) || (f3 > 3'd5);
        c.src_b_imm = 1'b1; c.mem_rd = 1'b1;
        c.reg_we = 1'b1; imm = imm_i;
      end
      opc == OP_STORE: begin
        bad = (f3 > 3'd2);
        c.src_b_imm = 1'b1; c.mem_we = 1'b1; imm = imm_s;
      end
      opc == OP_IMM: begin
        // Only shifts carry a funct7; SRAI is the one alternate form
        if (f3 == 3'd1) bad = (f7 != 7'h00);
        if (f3 == 3'd5) bad = (f7 != 7'h00) && (f7 != 7'h20);
        c.alu_op = alu_dec(f3, (f3 == 3'd5) && f7[5]);
        c.src_b_imm = 1'b1; c.reg_we = 1'b1; imm = imm_i;
      end
      opc == OP_OP: begin
        bad = !((f7 == 7'h00) ||
                (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        c.alu_op = alu_dec(f3, f7[5]);
        c.reg_we = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      c         = '0;
      c.funct3  = f3;
      c.rd      = ins[11:7];
      c.illegal = 1'b1;
    end
    if (c.rd == 5'd0) c.reg_we = 1'b0;
  end

  latch #(.W(DW)) u_data (
    .clk   (clk),
    .reset (reset),
    .en    (latch_en_i),
    .clear (latch_clear_i),
    .d     ({r1, r2, imm, pc_i}),
    .q     (dq)
  );

  latch #(.W($bits(id_ex_ctrl_t))) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .en    (latch_en_i),
    .clear (latch_clear_i),
    .d     (c),
    .q     (cq)
  );

  assign {rs1_data_o, rs2_data_o, imm_o, pc_o} = dq;

  assign rd_o            = cq.rd;
  assign funct3_o        = cq.funct3;
  assign alu_op_o        = cq.alu_op;
  assign alu_src_a_pc_o  = cq.src_a_pc;
  assign alu_src_b_imm_o = cq.src_b_imm;
  assign reg_we_o        = cq.reg_we;
  assign mem_we_o        = cq.mem_we;
  assign mem_rd_o        = cq.mem_rd;
  assign branch_o        = cq.branch;
  assign jump_o          = cq.jump;
  assign jalr_o          = cq.jalr;
  assign illegal_o       = cq.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage.
// Hand-computed expectations, immediate assertions.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_i, pc_i, wb_data_i;
  logic        wb_we_i, latch_en_i, latch_clear_i;
  logic [4:0]  wb_rd_i;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] rs1_data_o, rs2_data_o, imm_o, pc_o;
  logic [2:0]  funct3_o;
  logic [3:0]  alu_op_o;
  logic        alu_src_a_pc_o, alu_src_b_imm_o, reg_we_o;
  logic        mem_we_o, mem_rd_o, branch_o, jump_o, jalr_o;
  logic        illegal_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk             (clk),
    .reset           (reset),
    .instr_i         (instr_i),
    .pc_i            (pc_i),
    .wb_we_i         (wb_we_i),
    .wb_rd_i         (wb_rd_i),
    .wb_data_i       (wb_data_i),
    .latch_en_i      (latch_en_i),
    .latch_clear_i   (latch_clear_i),
    .rs1_o           (rs1_o),
    .rs2_o           (rs2_o),
    .rs1_data_o      (rs1_data_o),
    .rs2_data_o      (rs2_data_o),
    .imm_o           (imm_o),
    .pc_o            (pc_o),
    .rd_o            (rd_o),
    .funct3_o        (funct3_o),
    .alu_op_o        (alu_op_o),
    .alu_src_a_pc_o  (alu_src_a_pc_o),
    .alu_src_b_imm_o (alu_src_b_imm_o),
    .reg_we_o        (reg_we_o),
    .mem_we_o        (mem_we_o),
    .mem_rd_o        (mem_rd_o),
    .branch_o        (branch_o),
    .jump_o          (jump_o),
    .jalr_o          (jalr_o),
    .illegal_o       (illegal_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; instr_i = '0; pc_i = '0;
    wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    latch_en_i = 1'b1; latch_clear_i = 1'b0;
    tick;
    chk("rst_rd", 32'(rd_o), 0);
    chk("rst_imm", imm_o, 0);
    chk("rst_illegal", 32'(illegal_o), 0);
    chk("rst_we", 32'(reg_we_o), 0);
    reset = 1'b0;

    // addi x5,x0,7
    instr_i = 32'h00700293; pc_i = 32'h10;
    #1;
    chk("addi_rs2_comb", 32'(rs2_o), 7);
    tick;
    chk("addi_rd", 32'(rd_o), 5);
    chk("addi_imm", imm_o, 7);
    chk("addi_alu", 32'(alu_op_o), 0);
    chk("addi_srcb", 32'(alu_src_b_imm_o), 1);
    chk("addi_we", 32'(reg_we_o), 1);
    chk("addi_rs1d", rs1_data_o, 0);
    chk("addi_pc", pc_o, 32'h10);

    // add x6,x5,x5 with same-cycle WB of x5
    instr_i = 32'h00528333;
    wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h1234;
    tick;
    wb_we_i = 1'b0;
    chk("byp_rs1d", rs1_data_o, 32'h1234);
    chk("byp_rs2d", rs2_data_o, 32'h1234);
    chk("byp_rd", 32'(rd_o), 6);
    chk("byp_srcb", 32'(alu_src_b_imm_o), 0);

    // beq x1,x2,-8
    instr_i = 32'hFE208CE3;
    #1;
    chk("beq_rs1_comb", 32'(rs1_o), 1);
    chk("beq_rs2_comb", 32'(rs2_o), 2);
    tick;
    chk("beq_imm", imm_o, 32'hFFFFFFF8);
    chk("beq_br", 32'(branch_o), 1);
    chk("beq_f3", 32'(funct3_o), 0);
    chk("beq_we", 32'(reg_we_o), 0);
    chk("beq_alu", 32'(alu_op_o), 1);

    // write x0, then add x7,x0,x0
    instr_i = 32'h000003B3;
    wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'hDEAD;
    tick;
    wb_we_i = 1'b0;
    chk("x0_byp_rs1d", rs1_data_o, 0);
    tick;
    chk("x0_rs1d", rs1_data_o, 0);
    chk("x0_rd", 32'(rd_o), 7);
    chk("x0_we", 32'(reg_we_o), 1);

    // addi x0,x0,1
    instr_i = 32'h00100013;
    tick;
    chk("rd0_we", 32'(reg_we_o), 0);
    chk("rd0_illegal", 32'(illegal_o), 0);

    // add x8,x5,x0 : x5 kept from WB
    instr_i = 32'h00028433;
    tick;
    chk("x5_rs1d", rs1_data_o, 32'h1234);
    chk("x5_rd", 32'(rd_o), 8);

    // stall 3 cycles while WB writes x3
    latch_en_i = 1'b0;
    instr_i = 32'h00700293;
    wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'h55;
    for (int i = 0; i < 3; i++) begin
      tick;
      wb_we_i = 1'b0;
      chk("stall_rd", 32'(rd_o), 8);
      chk("stall_rs1d", rs1_data_o, 32'h1234);
      chk("stall_imm", imm_o, 0);
    end
    latch_en_i = 1'b1;

    // add x10,x3,x0
    instr_i = 32'h00018533;
    tick;
    chk("x3_rs1d", rs1_data_o, 32'h55);

    // clear together with enable
    latch_clear_i = 1'b1;
    instr_i = 32'h00700293; pc_i = 32'h44;
    tick;
    latch_clear_i = 1'b0;
    chk("clr_rd", 32'(rd_o), 0);
    chk("clr_imm", imm_o, 0);
    chk("clr_we", 32'(reg_we_o), 0);
    chk("clr_pc", pc_o, 0);
    chk("clr_illegal", 32'(illegal_o), 0);

    // lw x11,4(x2)
    instr_i = 32'h00412583; pc_i = 32'h100;
    tick;
    chk("lw_pc", pc_o, 32'h100);
    chk("lw_mrd", 32'(mem_rd_o), 1);
    chk("lw_f3", 32'(funct3_o), 2);
    chk("lw_imm", imm_o, 4);

    // sw x3,-4(x2)
    instr_i = 32'hFE312E23;
    tick;
    chk("sw_imm", imm_o, 32'hFFFFFFFC);
    chk("sw_mwe", 32'(mem_we_o), 1);
    chk("sw_we", 32'(reg_we_o), 0);

    // lui x12,0x12345
    instr_i = 32'h12345637;
    tick;
    chk("lui_imm", imm_o, 32'h12345000);
    chk("lui_alu", 32'(alu_op_o), 10);

    // auipc x5,1
    instr_i = 32'h00001297;
    tick;
    chk("auipc_imm", imm_o, 32'h1000);
    chk("auipc_srca", 32'(alu_src_a_pc_o), 1);

    // jal x1,+16
    instr_i = 32'h010000EF;
    tick;
    chk("jal_imm", imm_o, 16);
    chk("jal_jump", 32'(jump_o), 1);

    // jalr x1,8(x2)
    instr_i = 32'h008100E7;
    tick;
    chk("jalr_jalr", 32'(jalr_o), 1);
    chk("jalr_imm", imm_o, 8);

    // sra x13,x1,x2
    instr_i = 32'h4020D6B3;
    tick;
    chk("sra_alu", 32'(alu_op_o), 7);

    // funct7=0x20 with funct3=4 is illegal
    instr_i = 32'h4020C6B3;
    tick;
    chk("badf7_illegal", 32'(illegal_o), 1);
    chk("badf7_we", 32'(reg_we_o), 0);

    // all-zero word
    instr_i = 32'h00000000;
    tick;
    chk("zero_illegal", 32'(illegal_o), 1);
    chk("zero_we", 32'(reg_we_o), 0);

    // reset mid-stream
    instr_i = 32'h00700293;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mrst_rd", 32'(rd_o), 0);
    chk("mrst_imm", imm_o, 0);
    chk("mrst_illegal", 32'(illegal_o), 0);
    instr_i = 32'h00018533;
    tick;
    chk("mrst_x3", rs1_data_o, 0);
    chk("mrst_rd10", 32'(rd_o), 10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the RV32I core. Consumes the instruction word and its PC from the fetch-to-decode latch, reads the register file, generates the sign-extended immediate and control word, and registers everything into the decode-to-execute latch under the hazard unit's enable/clear. It also owns the architectural register file, written by the writeback stage.

## Interface
Parameters:
- `PC_W`, 32, PC width; the PC is a word address, one increment per instruction.
- `INSTR_W`, 32, instruction width.
- `XLEN`, 32, register/data width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `instr_i`  in  INSTR_W  instruction from the F/D latch.
- `pc_i`  in  PC_W  word PC of `instr_i`.
- `wb_we_i`  in  1  writeback write enable.
- `wb_rd_i`  in  5  writeback destination.
- `wb_data_i`  in  XLEN  writeback data.
- `latch_en_i`  in  1  D/E latch enable from the hazard unit (HU); 0 means stall.
- `latch_clear_i`  in  1  D/E flush from the HU.
- `rs1_o`, `rs2_o`  out  5  unregistered source indices to the HU.
- `rs1_data_o`, `rs2_data_o`  out  XLEN  registered operands.
- `imm_o`  out  XLEN  registered sign-extended byte immediate.
- `pc_o`  out  PC_W  registered PC.
- `rd_o`  out  5  registered destination.
- `funct3_o`  out  3  registered funct3, used for branch condition and memory size.
- `alu_op_o`  out  4  registered ALU operation.
- `alu_src_a_pc_o`, `alu_src_b_imm_o`  out  1  operand selects.
- `reg_we_o`, `mem_we_o`, `mem_rd_o`, `branch_o`, `jump_o`, `jalr_o`, `illegal_o`  out  1  registered control bits.

## Operation
- Supported decode: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode, or a bad funct3/funct7 combination, decodes as a bubble (all control bits 0) with `illegal_o`=1.
- Immediate formats I/S/B/U/J are produced per RISC-V, sign-extended to XLEN. B and J immediates are byte offsets; EX converts them to word PC.
- LUI sets `alu_src_a` to zero via `alu_op` = PASS_B.
- `reg_we_o` is forced to 0 when rd=0.
- Register file: 32×XLEN with two combinational read ports and one write port written on the posedge. x0 always reads 0, and writes to x0 are discarded.
- Write-first bypass: when `wb_we_i` && `wb_rd_i`==rsN && rsN≠0, the read returns `wb_data_i` in the same cycle.
- `rs1_o`/`rs2_o` are the raw instruction fields `instr_i[19:15]` and `[24:20]`, driven every cycle regardless of opcode.
- D/E latch priority: reset > clear > enable. Clear loads a bubble (every output 0). `latch_en_i`=0 holds all registered outputs unchanged. The register file write still occurs during a stall or clear.

## Timing
- Latency: 1 cycle from `instr_i` to the D/E outputs.
- HU outputs (`rs1_o`, `rs2_o`) are combinational, with 0-cycle latency.
- On reset, all registered outputs are 0, including `illegal_o`=0, and all 32 registers are cleared to 0 in the same cycle.
- Reset asserted mid-stream discards the in-flight instruction.
- Simultaneous `latch_clear_i` and `latch_en_i` produce a bubble.
- A WB write and a read of the same register in one cycle return the new data.

## Structure
- Package `core_pkg`:
  - opcode constants `OP_LUI`=0x37, `OP_AUIPC`=0x17, `OP_JAL`=0x6F, `OP_JALR`=0x67, `OP_BRANCH`=0x63, `OP_LOAD`=0x03, `OP_STORE`=0x23, `OP_IMM`=0x13, `OP_OP`=0x33;
  - enum `alu_op_t`: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
- Sub-module `regfile`: 2R1W with the write-first bypass and the x0 rule.
- The D/E registers reuse the existing `latch` module, one instance per field group.

## Test plan
- Reset, then `instr_i`=0x00700293 (addi x5,x0,7). Next cycle: `rd_o`=5, `imm_o`=7, `alu_op_o`=ADD, `alu_src_b_imm_o`=1, `reg_we_o`=1, `rs1_data_o`=0.
- Bypass: `wb_we_i`=1, `wb_rd_i`=5, `wb_data_i`=0x1234 in the same cycle as `instr_i`=0x00528333 (add x6,x5,x5). Next cycle: `rs1_data_o`=`rs2_data_o`=0x1234, `rd_o`=6.
- `instr_i`=0xFE208CE3 (beq x1,x2,-8). Expect `imm_o`=0xFFFFFFF8, `branch_o`=1, `funct3_o`=0, `reg_we_o`=0, `rs1_o`=1, `rs2_o`=2 combinationally.
- Write x0 with 0xDEAD, then decode add x7,x0,x0. Expect `rs1_data_o`=0. Separately, decode addi x0,x0,1 and expect `reg_we_o`=0.
- Stall and flush: with `latch_en_i`=0 for 3 cycles, outputs hold their values. `latch_clear_i`=1 together with `latch_en_i`=1 gives all outputs 0. `instr_i`=0x00000000 gives a bubble with `illegal_o`=1.
- Reset mid-stream after writing x3=0x55 gives outputs 0, and a subsequent read of x3 returns 0.
